exp_accel_avalon: RTL and testbench



---
 rtl/exp_accel_avalon.sv | 85 ++++++++
 tb/tb_exp_accel_avalon.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/exp_accel_avalon.sv
// exp_accel_avalon: Avalon-MM square-and-multiply power unit, BASE^EXP mod 2^WIDTH with sticky overflow; define EXP_ACCEL_IRQ_EN to implement IE and irq
module exp_accel_avalon #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             write,
  input  logic [WIDTH-1:0] writedata,
  input  logic             read,
  output logic [WIDTH-1:0] readdata,
  output logic             irq
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  logic [0:0]         state;
  logic [WIDTH-1:0]   base_r, exp_r, result_r, acc, b, e, rmux;
  logic [2*WIDTH-1:0] pa, pb;
  logic               busy, ie, done, ovf, bovf, wr_ctrl;
  assign busy    = state == RUN;
  assign wr_ctrl = write && address == 3'd0;
  assign pa      = acc * b;
  assign pb      = b * b;
  assign irq     = done & ie;
`ifdef EXP_ACCEL_IRQ_EN
  // interrupt enable stays writable even while a computation runs
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ie <= 1'b0;
    else if (wr_ctrl) ie <= writedata[1];
`else
  assign ie = 1'b0;
`endif
  // register file read mux; unmapped addresses read as zero
  always_comb begin
    rmux = address == 3'd0 ? {{(WIDTH-4){1'b0}}, ovf, done, ie, busy} :
           address == 3'd1 ? base_r :
           address == 3'd2 ? exp_r :
           address == 3'd3 ? result_r : '0;
  end
  // read data is registered, giving a read latency of one cycle
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) readdata <= '0;
    else if (read) readdata <= rmux;
  // operand registers, control FSM and one exponent bit per RUN cycle
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state    <= IDLE;
      base_r   <= '0;
      exp_r    <= '0;
      result_r <= '0;
      acc      <= '0;
      b        <= '0;
      e        <= '0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      bovf     <= 1'b0;
    end else begin
      if (wr_ctrl && writedata[2]) done <= 1'b0;
      if (state == IDLE) begin
        if (write && address == 3'd1) base_r <= writedata;
        if (write && address == 3'd2) exp_r <= writedata;
        if (wr_ctrl && writedata[0]) begin
          acc   <= {{(WIDTH-1){1'b0}}, 1'b1};
          b     <= base_r;
          e     <= exp_r;
          done  <= 1'b0;
          ovf   <= 1'b0;
          bovf  <= 1'b0;
          state <= RUN;
        end
      end else if (e == '0) begin
        result_r <= acc;
        done     <= 1'b1;
        state    <= IDLE;
      end else begin
        if (e[0]) begin
          acc <= pa[WIDTH-1:0];
          ovf <= ovf | (|pa[2*WIDTH-1:WIDTH]) | bovf;
        end
        b    <= pb[WIDTH-1:0];
        bovf <= bovf | (|pb[2*WIDTH-1:WIDTH]);
        e    <= e >> 1;
      end
    end
endmodule

// File: tb/tb_exp_accel_avalon.sv
// tb_exp_accel_avalon: scoreboard bench for exp_accel_avalon against a naive power model
module tb_exp_accel_avalon;
`ifdef EXP_ACCEL_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif
  logic        clk = 1'b0, reset_n = 1'b0, write = 1'b0, read = 1'b0, irq, pend;
  logic [2:0]  address = '0;
  logic [31:0] writedata = '0, readdata;
  int compared = 0, mismatched = 0;
  typedef struct {
    logic [31:0] d;
    logic [31:0] m;
    logic        irq;
    string       name;
  } exp_t;
  exp_t q[$];

  exp_accel_avalon #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .write(write),
    .writedata(writedata), .read(read), .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n)
    if (!reset_n) pend <= 1'b0;
    else pend <= read;

  // monitor: every completed read pops one expectation
  always @(negedge clk)
    if (pend) begin
      if (q.size() == 0) begin
        mismatched++;
        $display("FAIL underflow: read data %h with no expectation", readdata);
      end else begin
        exp_t x;
        x = q.pop_front();
        compared += 2;
        if ((readdata & x.m) !== (x.d & x.m)) begin
          mismatched++;
          $display("FAIL %s: readdata got %h want %h (mask %h)", x.name, readdata, x.d, x.m);
        end
        if (irq !== x.irq) begin
          mismatched++;
          $display("FAIL %s_irq: irq got %b want %b", x.name, irq, x.irq);
        end
      end
    end

  task automatic chk(input string name, input logic [31:0] got, want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    write = 1'b0;
    read  = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    write = 1'b1; read = 1'b0; address = a; writedata = d;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] d, m, input logic iq, input string name);
    exp_t x;
    @(negedge clk);
    write = 1'b0; read = 1'b1; address = a;
    x.d = d; x.m = m; x.irq = iq; x.name = name;
    q.push_back(x);
  endtask

  // reference: BASE multiplied into itself EXP times; overflow means the true power reaches 2^32
  task automatic ref_pow(input logic [31:0] bb, ee, output logic [31:0] r, output bit ov);
    longint unsigned p;
    r = 1; ov = 0; p = 1;
    if (ee <= 1000) begin
      for (int i = 0; i < int'(ee); i++) begin
        r = r * bb;
        if (!ov) begin
          p = p * bb;
          if (p >= 64'h1_0000_0000) ov = 1;
        end
      end
    end else if (bb <= 1) r = bb;
    else if (bb[0] == 1'b0) begin
      r = 0; ov = 1;
    end else $fatal(1, "FAIL ref_pow: odd base with large exponent not modelled");
  endtask

  function automatic int blen(input logic [31:0] v);
    int k = 0;
    for (int i = 0; i < 32; i++) if (v[i]) k = i + 1;
    return k;
  endfunction

  task automatic run(input logic [31:0] bb, ee, input logic ie, input bit inject);
    logic [31:0] r;
    bit ov;
    int k;
    logic iev;
    iev = ie & IRQ;
    ref_pow(bb, ee, r, ov);
    k = blen(ee);
    wr(3'd1, bb);
    wr(3'd2, ee);
    wr(3'd0, {30'b0, ie, 1'b1});
    for (int j = 1; j <= k + 2; j++) begin
      if (inject && j == 1) wr(3'd1, 32'd9);
      else if (inject && j == 2) wr(3'd0, {30'b0, ie, 1'b1});
      else if (j <= k + 1) rd(3'd0, {28'b0, 1'b0, 1'b0, iev, 1'b1}, ~32'h8, (j <= k) ? 1'b0 : iev, "busy");
      else rd(3'd0, {28'b0, ov, 1'b1, iev, 1'b0}, '1, iev, "status");
    end
    rd(3'd3, r, '1, iev, "result");
    rd(3'd1, bb, '1, iev, "base");
  endtask

  initial begin
    logic [31:0] bb, ee;
    int mode;
    repeat (2) @(negedge clk);
    chk("reset_readdata", readdata, 32'h0);
    chk("reset_irq", {31'b0, irq}, 32'h0);
    reset_n = 1'b1;
    rd(3'd0, 32'h0, '1, 1'b0, "rst_ctrl");
    rd(3'd1, 32'h0, '1, 1'b0, "rst_base");
    rd(3'd2, 32'h0, '1, 1'b0, "rst_exp");
    rd(3'd3, 32'h0, '1, 1'b0, "rst_result");
    wr(3'd5, 32'hdead_beef);
    rd(3'd5, 32'h0, '1, 1'b0, "unmapped");
    run(32'd3, 32'd5, 1'b0, 1'b0);
    run(32'd7, 32'd0, 1'b0, 1'b0);
    run(32'd0, 32'd0, 1'b0, 1'b0);
    run(32'd2, 32'd32, 1'b0, 1'b0);
    run(32'd2, 32'd31, 1'b0, 1'b0);
    run(32'd3, 32'd5, 1'b0, 1'b1);
    run(32'd5, 32'd3, 1'b1, 1'b0);
    wr(3'd0, 32'h6);
    rd(3'd0, {28'b0, 1'b0, 1'b0, IRQ, 1'b0}, '1, 1'b0, "done_clr");
    for (int n = 0; n < 24; n++) begin
      mode = $urandom_range(0, 3);
      case (mode)
        0: begin bb = $urandom; ee = $urandom_range(0, 40); end
        1: begin bb = $urandom_range(0, 5); ee = $urandom_range(0, 400); end
        2: begin bb = $urandom << 1; if (bb == 0) bb = 2; ee = $urandom | 32'h0000_0800; end
        default: begin bb = $urandom_range(0, 1); ee = $urandom; end
      endcase
      run(bb, ee, 1'($urandom_range(0, 1)), 1'b0);
    end
    wr(3'd1, 32'd3);
    wr(3'd2, 32'd20);
    wr(3'd0, 32'h3);
    idle();
    idle();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrun_reset_readdata", readdata, 32'h0);
    chk("midrun_reset_irq", {31'b0, irq}, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rd(3'd0, 32'h0, '1, 1'b0, "post_rst_ctrl");
    rd(3'd1, 32'h0, '1, 1'b0, "post_rst_base");
    rd(3'd2, 32'h0, '1, 1'b0, "post_rst_exp");
    rd(3'd3, 32'h0, '1, 1'b0, "post_rst_result");
    run(32'd3, 32'd20, 1'b1, 1'b0);
    repeat (3) idle();
    chk("queue_drained", q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
